// File: rtl/ps2_key_event_fifo.sv
// PS/2 set-2 scan-code decoder feeding a first-word-fall-through key-event FIFO.
// Ports: clk, reset (async high); rx_dato/rx_listo byte strobe in; rd_en pop;
// ovf_clr clears the sticky overflow; evento {ext,brk,code}, vacio, lleno,
// cuenta, overflow out. Optional macro PS2_TYPEMATIC_FILTER_EN drops autorepeat makes.
module ps2_key_event_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_dato,
  input  logic              rx_listo,
  input  logic              rd_en,
  input  logic              ovf_clr,
  output logic [9:0]        evento,
  output logic              vacio,
  output logic              lleno,
  output logic [ADDR_W:0]   cuenta,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE, PRE_E0, PRE_F0, PRE_E0F0
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_PTR = ADDR_W'(1);

  state_t state_q, state_d;
  logic   is_disc, ext_p, brk_p;
  logic   emit, push_req;
  logic [9:0] ev;

  logic [9:0]        mem_q [FIFO_DEPTH];
  logic [9:0]        mem_d [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   cuenta_q, cuenta_d;
  logic              ovf_q, ovf_d;
  logic              pop, wr;

  always_comb begin
    is_disc = (rx_dato inside {8'h00, 8'hAA, 8'hEE, 8'hFA,
                               8'hFC, 8'hFD, 8'hFE, 8'hFF});
  end

  // Prefix flags already collected in the current sequence.
  assign ext_p = (state_q == PRE_E0) || (state_q == PRE_E0F0);
  assign brk_p = (state_q == PRE_F0) || (state_q == PRE_E0F0);

  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    ev      = 10'h000;
    if (rx_listo) begin
      unique case (1'b1)
        rx_dato == 8'hE0: state_d = brk_p ? PRE_E0F0 : PRE_E0;
        rx_dato == 8'hF0: state_d = ext_p ? PRE_E0F0 : PRE_F0;
        default: begin
          state_d = IDLE;
          if (!is_disc) begin
            emit = 1'b1;
            ev   = {ext_p, brk_p, rx_dato};
          end
        end
      endcase
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       held_v_q, held_v_d;
  logic [8:0] held_k_q, held_k_d;
  logic       held_hit;

  assign held_hit = held_v_q && (held_k_q == {ev[9], ev[7:0]});

  always_comb begin
    push_req = emit;
    held_v_d = held_v_q;
    held_k_d = held_k_q;
    if (emit) begin
      if (!ev[8]) begin
        // Repeat of the key already down is autorepeat, not a new press.
        if (held_hit) begin
          push_req = 1'b0;
        end else begin
          held_v_d = 1'b1;
          held_k_d = {ev[9], ev[7:0]};
        end
      end else if (held_hit) begin
        held_v_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_v_q <= 1'b0;
      held_k_q <= '0;
    end else begin
      held_v_q <= held_v_d;
      held_k_q <= held_k_d;
    end
  end
`else
  assign push_req = emit;
`endif

  assign vacio    = (cuenta_q == '0);
  assign lleno    = (cuenta_q == FULL_CNT);
  assign cuenta   = cuenta_q;
  assign overflow = ovf_q;
  assign evento   = mem_q[rd_ptr_q];

  // When full, a simultaneous pop frees the slot the write lands in.
  assign pop = rd_en && !vacio;
  assign wr  = push_req && (!lleno || pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cuenta_d = cuenta_q;
    ovf_d    = ovf_q;
    if (wr) begin
      mem_d[wr_ptr_q] = ev;
      wr_ptr_d        = wr_ptr_q + ONE_PTR;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ONE_PTR;
    end
    unique case ({wr, pop})
      2'b10:   cuenta_d = cuenta_q + ONE_CNT;
      2'b01:   cuenta_d = cuenta_q - ONE_CNT;
      default: cuenta_d = cuenta_q;
    endcase
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (push_req && lleno && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cuenta_q <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cuenta_q <= cuenta_d;
      ovf_q    <= ovf_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Randomised bench for ps2_key_event_fifo with a queue-based reference model.
// Directed literal checks pin the model; a negedge process compares every cycle.
module tb_ps2_key_event_fifo;

  localparam int DEPTH = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_dato = 8'h00;
  logic          rx_listo = 1'b0;
  logic          rd_en = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [9:0]    evento;
  logic          vacio, lleno, overflow;
  logic [AW:0]   cuenta;

  int total = 0;
  int bad = 0;

  ps2_key_event_fifo #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .rx_dato(rx_dato), .rx_listo(rx_listo),
    .rd_en(rd_en), .ovf_clr(ovf_clr),
    .evento(evento), .vacio(vacio), .lleno(lleno),
    .cuenta(cuenta), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: pending prefix flags, event queue, sticky overflow.
  logic [9:0] m_q[$];
  bit         m_ext, m_brk, m_ovf;
  bit         m_hv;
  logic [8:0] m_hk;

  function automatic bit discard(input logic [7:0] b);
    return b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA ||
           b == 8'hFC || b == 8'hFD || b == 8'hFE || b == 8'hFF;
  endfunction

  always @(posedge clk) begin
    bit         em, pp, full;
    logic [9:0] e;
    if (reset) begin
      m_q.delete();
      m_ext = 0; m_brk = 0; m_ovf = 0; m_hv = 0; m_hk = '0;
    end else begin
      em = 0; e = '0;
      if (rx_listo) begin
        if (rx_dato == 8'hE0) m_ext = 1;
        else if (rx_dato == 8'hF0) m_brk = 1;
        else begin
          if (!discard(rx_dato)) begin
            em = 1; e = {m_ext, m_brk, rx_dato};
          end
          m_ext = 0; m_brk = 0;
        end
      end
`ifdef PS2_TYPEMATIC_FILTER_EN
      if (em) begin
        if (!e[8]) begin
          if (m_hv && m_hk == {e[9], e[7:0]}) em = 0;
          else begin m_hv = 1; m_hk = {e[9], e[7:0]}; end
        end else if (m_hv && m_hk == {e[9], e[7:0]}) m_hv = 0;
      end
`endif
      full = (m_q.size() == DEPTH);
      pp = rd_en && (m_q.size() > 0);
      if (pp) void'(m_q.pop_front());
      if (ovf_clr) m_ovf = 0;
      if (em) begin
        if (full && !pp) m_ovf = 1;
        else m_q.push_back(e);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("cuenta", int'(cuenta), m_q.size());
      chk("vacio", int'(vacio), int'(m_q.size() == 0));
      chk("lleno", int'(lleno), int'(m_q.size() == DEPTH));
      chk("overflow", int'(overflow), int'(m_ovf));
      if (m_q.size() > 0) chk("evento", int'(evento), int'(m_q[0]));
    end
  end

  task automatic cyc(input logic l, input logic [7:0] d,
                     input logic r, input logic c);
    rx_listo = l; rx_dato = d; rd_en = r; ovf_clr = c;
    @(negedge clk);
    rx_listo = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic pop1();
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic reset_dut();
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] codes [5];
    logic [7:0] discs [8];
    codes = '{8'h1C, 8'h1D, 8'h75, 8'h15, 8'h6B};
    discs = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
    @(negedge clk);
    reset_dut();
    chk("rst_vacio", int'(vacio), 1);
    chk("rst_lleno", int'(lleno), 0);
    chk("rst_cuenta", int'(cuenta), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_evento", int'(evento), 'h000);

    send(8'h1C);
    chk("make_ev", int'(evento), 'h01C);
    chk("make_cnt", int'(cuenta), 1);
    pop1();
    chk("pop_empty", int'(vacio), 1);

    send(8'hE0); send(8'hF0); send(8'h75);
    chk("extbrk_ev", int'(evento), 'h375);
    chk("extbrk_cnt", int'(cuenta), 1);
    pop1();
    send(8'hF0); send(8'h1C);
    chk("brk_ev", int'(evento), 'h11C);
    pop1();

    send(8'hAA); send(8'hFA); send(8'hE0); send(8'hFE);
    chk("disc_empty", int'(vacio), 1);
    send(8'h1C);
    chk("after_disc", int'(evento), 'h01C);
    pop1();

    reset_dut();
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
    chk("ovf_full", int'(lleno), 1);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_head", int'(evento), 'h015);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", int'(overflow), 0);
    cyc(1'b1, 8'h3C, 1'b1, 1'b0);
    chk("fullrw_cnt", int'(cuenta), 4);
    chk("fullrw_ovf", int'(overflow), 0);
    chk("fullrw_head", int'(evento), 'h01D);
    pop1(); chk("pop_24", int'(evento), 'h024);
    pop1(); chk("pop_2d", int'(evento), 'h02D);
    pop1(); chk("pop_3c", int'(evento), 'h03C);
    pop1(); chk("pop_done", int'(vacio), 1);

    send(8'hE0);
    reset_dut();
    send(8'h1C);
    chk("rst_mid", int'(evento), 'h01C);

    reset_dut();
    send(8'h1C); send(8'h1C); send(8'h1C);
    send(8'hF0); send(8'h1C); send(8'h1C);
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("filt_cnt", int'(cuenta), 3);
    chk("filt_ovf", int'(overflow), 0);
    chk("filt_e0", int'(evento), 'h01C);
    pop1(); chk("filt_e1", int'(evento), 'h11C);
    pop1(); chk("filt_e2", int'(evento), 'h01C);
`else
    chk("nofilt_cnt", int'(cuenta), 4);
    chk("nofilt_ovf", int'(overflow), 1);
    chk("nofilt_e0", int'(evento), 'h01C);
`endif

    for (int i = 0; i < 4000; i++) begin
      logic       l, r, c;
      logic [7:0] b;
      int         k;
      if ($urandom_range(0, 699) == 0) reset_dut();
      k = $urandom_range(0, 9);
      if (k < 2) b = 8'hE0;
      else if (k < 4) b = 8'hF0;
      else if (k == 4) b = discs[$urandom_range(0, 7)];
      else b = codes[$urandom_range(0, 4)];
      l = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 9) < 3);
      c = ($urandom_range(0, 19) == 0);
      cyc(l, b, r, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
